// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The arbitration policy is selected by the DMEM_ARB_RR_EN macro (see dmem_arb_pick).
package dmem_arb_pkg;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_AUX = 1'b1
    } port_e;

    localparam int MEM_ADDR_W       = 32;
    localparam int MEM_DATA_W       = 32;
    localparam int MAX_WAIT_DEFAULT = 4;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // Width of a counter that must hold 0..max_wait inclusive.
    function automatic int cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the data-memory arbiter.
// DMEM_ARB_RR_EN defined: round-robin on rr_last; undefined: port 0 priority with starvation override.
module dmem_arb_pick
    import dmem_arb_pkg::*;
`ifndef DMEM_ARB_RR_EN
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int CNT_W    = cnt_width(MAX_WAIT_DEFAULT)
)
`endif
(
    input  logic             req0,
    input  logic             req1,
`ifdef DMEM_ARB_RR_EN
    input  port_e            rr_last,
`else
    input  logic [CNT_W-1:0] wait_cnt,
`endif
    output logic             gnt0,
    output logic             gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
            if (rr_last == PORT_CPU) gnt1 = 1'b1;
            else                     gnt0 = 1'b1;
`else
            // Port 1 has been refused long enough; it takes this contention.
            if (wait_cnt == CNT_W'(MAX_WAIT)) gnt1 = 1'b1;
            else                              gnt0 = 1'b1;
`endif
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory (1-cycle read latency).
// Policy macro: DMEM_ARB_RR_EN (defined = round-robin, undefined = fixed priority + MAX_WAIT override).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic     gnt0, gnt1;
    logic     rd_gnt;
    mem_req_t req0_s, req1_s, win_s;

    logic              pending_q, pending_d;
    port_e             pend_port_q, pend_port_d;
    logic              p0_rvalid_q, p0_rvalid_d;
    logic              p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

`ifdef DMEM_ARB_RR_EN
    port_e rr_last_q, rr_last_d;

    dmem_arb_pick u_pick (
        .req0    (p0_req),
        .req1    (p1_req),
        .rr_last (rr_last_q),
        .gnt0    (gnt0),
        .gnt1    (gnt1)
    );
`else
    localparam int CNT_W = cnt_width(MAX_WAIT);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    dmem_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_pick (
        .req0     (p0_req),
        .req1     (p1_req),
        .wait_cnt (wait_cnt_q),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );
`endif

    always_comb begin
        req0_s = '{we: p0_we, addr: MEM_ADDR_W'(p0_addr), wdata: MEM_DATA_W'(p0_wdata)};
        req1_s = '{we: p1_we, addr: MEM_ADDR_W'(p1_addr), wdata: MEM_DATA_W'(p1_wdata)};
        win_s  = '0;
        if (gnt0)      win_s = req0_s;
        else if (gnt1) win_s = req1_s;
    end

    assign rd_gnt    = (gnt0 | gnt1) & ~win_s.we;
    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign mem_addr  = ADDR_W'(win_s.addr);
    assign mem_wdata = DATA_W'(win_s.wdata);
    assign mem_write = win_s.we;
    // Read enable stays up in the cycle after a read grant so the memory keeps driving its data.
    assign mem_read  = rd_gnt | pending_q;

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

    always_comb begin
        pending_d   = rd_gnt;
        pend_port_d = gnt1 ? PORT_AUX : PORT_CPU;
        p0_rvalid_d = pending_q & (pend_port_q == PORT_CPU);
        p1_rvalid_d = pending_q & (pend_port_q == PORT_AUX);
        p0_rdata_d  = p0_rvalid_d ? mem_rdata : '0;
        p1_rdata_d  = p1_rvalid_d ? mem_rdata : '0;
`ifdef DMEM_ARB_RR_EN
        rr_last_d = rr_last_q;
        if (gnt0)      rr_last_d = PORT_CPU;
        else if (gnt1) rr_last_d = PORT_AUX;
`else
        wait_cnt_d = wait_cnt_q;
        if (!p1_req || gnt1)                    wait_cnt_d = '0;
        else if (wait_cnt_q != CNT_W'(MAX_WAIT)) wait_cnt_d = wait_cnt_q + 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q   <= 1'b0;
            pend_port_q <= PORT_CPU;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_last_q   <= PORT_AUX;
`else
            wait_cnt_q  <= '0;
`endif
        end else begin
            pending_q   <= pending_d;
            pend_port_q <= pend_port_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
`ifdef DMEM_ARB_RR_EN
            rr_last_q   <= rr_last_d;
`else
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_write, mem_read;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata)
    );

    // Single-port synchronous memory: address registered on a read, write wins a shared cycle.
    logic [DW-1:0] mem_arr [0:255];
    logic [7:0]    raddr;
    logic          mem_clear;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
            raddr <= '0;
        end else if (mem_write) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
        end else if (mem_read) begin
            raddr <= mem_addr[9:2];
        end
    end
    assign mem_rdata = mem_read ? mem_arr[raddr] : '0;

    // Reference model state: memory contents and outstanding read responses.
    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } resp_t;

    logic [DW-1:0] ref_mem [0:255];
    resp_t         rq[$];
    int            m_wait;
    int            m_last;
    int            cyc;
    int            n_chk;
    int            n_fail;
    bit            g0, g1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
            $error("check %s", tag);
        end
    endtask

    task automatic set0(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set1(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return {22'd0, 4'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
    endfunction

    // One clock cycle: predict grants and outputs, compare at the falling edge, advance the model.
    task automatic step(output bit eg0, output bit eg1);
        bit            ew, rd, rv0, rv1, pend_prev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, rd0, rd1;
        @(negedge clk);
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (p0_req && p1_req) begin
`ifdef DMEM_ARB_RR_EN
            if (m_last == 1) eg0 = 1'b1; else eg1 = 1'b1;
`else
            if (m_wait == MW) eg1 = 1'b1; else eg0 = 1'b1;
`endif
        end else begin
            eg0 = p0_req;
            eg1 = p1_req;
        end
        ew = 1'b0; ea = '0; ewd = '0;
        if (eg0)      begin ew = p0_we; ea = p0_addr; ewd = p0_wdata; end
        else if (eg1) begin ew = p1_we; ea = p1_addr; ewd = p1_wdata; end
        rd = (eg0 || eg1) && !ew;
        rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0; pend_prev = 1'b0;
        foreach (rq[k]) begin
            if (rq[k].due == cyc) begin
                if (rq[k].port == 0) begin rv0 = 1'b1; rd0 = rq[k].data; end
                else                 begin rv1 = 1'b1; rd1 = rq[k].data; end
            end
            if (rq[k].due == cyc + 1) pend_prev = 1'b1;
        end
        if (reset) begin
            rv0 = 1'b0; rv1 = 1'b0; rd0 = '0; rd1 = '0; pend_prev = 1'b0;
        end
        chk("p0_gnt", p0_gnt, eg0);
        chk("p1_gnt", p1_gnt, eg1);
        chk("mem_write", mem_write, ew);
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_read", mem_read, rd || pend_prev);
        chk("p0_rvalid", p0_rvalid, rv0);
        chk("p0_rdata", p0_rdata, rd0);
        chk("p1_rvalid", p1_rvalid, rv1);
        chk("p1_rdata", p1_rdata, rd1);
        while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        if (reset) begin
            rq.delete();
            m_wait = 0;
            m_last = 1;
        end else begin
            if (rd) rq.push_back('{due: cyc + 2, port: (eg1 ? 1 : 0), data: ref_mem[ea[9:2]]});
            if ((eg0 || eg1) && ew) ref_mem[ea[9:2]] = ewd;
            if (!p1_req || eg1)  m_wait = 0;
            else if (m_wait < MW) m_wait++;
            if (eg0)      m_last = 0;
            else if (eg1) m_last = 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; m_wait = 0; m_last = 1;
        g0 = 1'b0; g1 = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        reset = 1'b1;
        mem_clear = 1'b1;
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        mem_clear = 1'b0;

        // Reset state
        chk("rst_p0_rvalid", p0_rvalid, 1'b0);
        chk("rst_p0_rdata", p0_rdata, 32'h0);
        chk("rst_p1_rvalid", p1_rvalid, 1'b0);
        chk("rst_p1_rdata", p1_rdata, 32'h0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        reset = 1'b0;
        step(g0, g1);

        // Write then read-back on consecutive cycles
        set0(1, 1, 32'h10, 32'hDEADBEEF);
        #1 chk("t1_wr_gnt", p0_gnt, 1'b1);
        step(g0, g1);
        set0(1, 0, 32'h10, 32'h0);
        #1 chk("t1_rd_gnt", p0_gnt, 1'b1);
        step(g0, g1);
        set0(0, 0, '0, '0);
        step(g0, g1);
        chk("t1_rvalid", p0_rvalid, 1'b1);
        chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
        step(g0, g1);

        // Preload 0x20/0x24, then simultaneous reads
        set0(1, 1, 32'h20, 32'h11);
        step(g0, g1);
        set0(1, 1, 32'h24, 32'h22);
        step(g0, g1);
        set0(0, 0, '0, '0);
        step(g0, g1);
        set0(1, 0, 32'h20, '0);
        set1(1, 0, 32'h24, '0);
`ifndef DMEM_ARB_RR_EN
        #1 chk("t2_first_p0", p0_gnt, 1'b1);
        chk("t2_first_p1", p1_gnt, 1'b0);
`endif
        step(g0, g1);
        if (g0) p0_req = 1'b0;
        if (g1) p1_req = 1'b0;
`ifndef DMEM_ARB_RR_EN
        #1 chk("t2_second_p1", p1_gnt, 1'b1);
`endif
        step(g0, g1);
        if (g0) p0_req = 1'b0;
        if (g1) p1_req = 1'b0;
`ifndef DMEM_ARB_RR_EN
        chk("t2_rv0", p0_rvalid, 1'b1);
        chk("t2_rd0", p0_rdata, 32'h11);
        chk("t2_rv1_early", p1_rvalid, 1'b0);
`endif
        step(g0, g1);
`ifndef DMEM_ARB_RR_EN
        chk("t2_rv1", p1_rvalid, 1'b1);
        chk("t2_rd1", p1_rdata, 32'h22);
        chk("t2_rv0_late", p0_rvalid, 1'b0);
`endif
        step(g0, g1);

        // Port 0 streaming, port 1 waiting from the start
        set0(1, 0, 32'h20, '0);
        set1(1, 0, 32'h24, '0);
        for (int i = 0; i < 10; i++) begin
`ifndef DMEM_ARB_RR_EN
            #1 chk("t3_p1_gnt", p1_gnt, (i == 4));
            chk("t3_p0_gnt", p0_gnt, (i != 4));
`endif
            step(g0, g1);
            if (g1) p1_req = 1'b0;
        end
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        repeat (3) step(g0, g1);

        // Both ports reading continuously; last grant made to port 1 first
        set1(1, 0, 32'h24, '0);
        step(g0, g1);
        set1(0, 0, '0, '0);
        set0(1, 0, 32'h20, '0);
        set1(1, 0, 32'h24, '0);
        for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_RR_EN
            #1 chk("t4_p0_gnt", p0_gnt, (i % 2 == 0));
            chk("t4_p1_gnt", p1_gnt, (i % 2 == 1));
`endif
            step(g0, g1);
        end
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        repeat (3) step(g0, g1);

        // Reset in the cycle after a read grant
        set0(1, 0, 32'h10, '0);
        step(g0, g1);
        set0(0, 0, '0, '0);
        reset = 1'b1;
        #1;
        chk("t5_p0_rvalid", p0_rvalid, 1'b0);
        chk("t5_p0_rdata", p0_rdata, 32'h0);
        chk("t5_p1_rvalid", p1_rvalid, 1'b0);
        chk("t5_mem_read", mem_read, 1'b0);
        chk("t5_mem_write", mem_write, 1'b0);
        chk("t5_mem_addr", mem_addr, 32'h0);
        step(g0, g1);
        step(g0, g1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_rvalid", p0_rvalid, 1'b0);
            step(g0, g1);
        end
        set0(1, 0, 32'h10, '0);
        step(g0, g1);
        set0(0, 0, '0, '0);
        step(g0, g1);
        chk("t5_after_rv", p0_rvalid, 1'b1);
        chk("t5_after_rd", p0_rdata, 32'hDEADBEEF);
        step(g0, g1);
        step(g0, g1);

        // Idle and write-only traffic never raises a read
        for (int i = 0; i < 8; i++) begin
            set0($urandom_range(0, 1) == 1, 1, 32'h40 + 32'(i * 4), $urandom());
            set1($urandom_range(0, 1) == 1, 1, 32'h80 + 32'(i * 4), $urandom());
            #1 chk("t6_mem_read", mem_read, 1'b0);
            chk("t6_rv0", p0_rvalid, 1'b0);
            chk("t6_rd0", p0_rdata, 32'h0);
            chk("t6_rv1", p1_rvalid, 1'b0);
            chk("t6_rd1", p1_rdata, 32'h0);
            step(g0, g1);
        end
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        step(g0, g1);

        // Random traffic with hold-until-grant handshake and occasional withdrawal
        for (int i = 0; i < 400; i++) begin
            if (!p0_req || g0)
                set0($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
            else if ($urandom_range(0, 7) == 0)
                p0_req = 1'b0;
            if (!p1_req || g1)
                set1($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(), $urandom());
            else if ($urandom_range(0, 7) == 0)
                p1_req = 1'b0;
            step(g0, g1);
        end
        set0(0, 0, '0, '0);
        set1(0, 0, '0, '0);
        repeat (3) step(g0, g1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
